// File: rtl/watch_time_tx.sv
// Sends the latched time as an ASCII "HH:MM:SS.CC" report over an 8N1 UART line.
// Define WATCH_TIME_TX_CRLF_EN to append a CR/LF terminator (13 chars instead of 11).
module watch_time_tx #(
   parameter int unsigned CLK_FREQ = 100_000_000,
   parameter int unsigned BAUD     = 9600
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       send_req,
   input  logic [4:0] hour,
   input  logic [5:0] min,
   input  logic [5:0] sec,
   input  logic [6:0] csec,
   output logic       tx,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int unsigned BIT_CYC = CLK_FREQ / BAUD;
   localparam int unsigned CW      = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
`ifdef WATCH_TIME_TX_CRLF_EN
   localparam logic [3:0] LAST_IDX = 4'd12;
`else
   localparam logic [3:0] LAST_IDX = 4'd10;
`endif

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_t;

   state_t          r_state;
   logic [CW-1:0]   r_baud_cnt;
   logic [2:0]      r_bit_cnt;
   logic [3:0]      r_char_idx;
   logic [6:0]      r_shift;
   logic [4:0]      r_hour;
   logic [5:0]      r_min;
   logic [5:0]      r_sec;
   logic [6:0]      r_csec;
   logic            r_tx;
   logic            r_busy;
   logic            r_done;

   logic [7:0]      w_char;
   logic            w_baud_end;

   function automatic logic [7:0] tens_ascii(input logic [6:0] v);
      logic [6:0] t;
      t = (v / 7'd10) % 7'd10;
      return 8'h30 + {1'b0, t};
   endfunction

   function automatic logic [7:0] ones_ascii(input logic [6:0] v);
      logic [6:0] o;
      o = v % 7'd10;
      return 8'h30 + {1'b0, o};
   endfunction

   // Character of the report selected by the current index, from the latched fields.
   always_comb begin
      w_char = 8'h0A;
      case (r_char_idx)
         4'd0:    w_char = tens_ascii({2'b00, r_hour});
         4'd1:    w_char = ones_ascii({2'b00, r_hour});
         4'd2:    w_char = 8'h3A;
         4'd3:    w_char = tens_ascii({1'b0, r_min});
         4'd4:    w_char = ones_ascii({1'b0, r_min});
         4'd5:    w_char = 8'h3A;
         4'd6:    w_char = tens_ascii({1'b0, r_sec});
         4'd7:    w_char = ones_ascii({1'b0, r_sec});
         4'd8:    w_char = 8'h2E;
         4'd9:    w_char = tens_ascii(r_csec);
         4'd10:   w_char = ones_ascii(r_csec);
         4'd11:   w_char = 8'h0D;
         default: w_char = 8'h0A;
      endcase
   end

   assign w_baud_end = (r_baud_cnt == CW'(BIT_CYC - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= StIdle;
         r_baud_cnt <= '0;
         r_bit_cnt  <= '0;
         r_char_idx <= '0;
         r_shift    <= '0;
         r_hour     <= '0;
         r_min      <= '0;
         r_sec      <= '0;
         r_csec     <= '0;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            StIdle: begin
               r_baud_cnt <= '0;
               if (send_req) begin
                  r_hour     <= hour;
                  r_min      <= min;
                  r_sec      <= sec;
                  r_csec     <= csec;
                  r_char_idx <= '0;
                  r_busy     <= 1'b1;
                  r_tx       <= 1'b0;
                  r_state    <= StStart;
               end
            end
            StStart: begin
               if (w_baud_end) begin
                  r_baud_cnt <= '0;
                  r_bit_cnt  <= '0;
                  r_shift    <= w_char[7:1];
                  r_tx       <= w_char[0];
                  r_state    <= StData;
               end else begin
                  r_baud_cnt <= r_baud_cnt + CW'(1);
               end
            end
            StData: begin
               if (w_baud_end) begin
                  r_baud_cnt <= '0;
                  if (r_bit_cnt == 3'd7) begin
                     r_tx    <= 1'b1;
                     r_state <= StStop;
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                     r_tx      <= r_shift[0];
                     r_shift   <= {1'b0, r_shift[6:1]};
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt + CW'(1);
               end
            end
            StStop: begin
               if (w_baud_end) begin
                  r_baud_cnt <= '0;
                  // Next start bit follows the stop bit with no idle gap.
                  if (r_char_idx < LAST_IDX) begin
                     r_char_idx <= r_char_idx + 4'd1;
                     r_tx       <= 1'b0;
                     r_state    <= StStart;
                  end else begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= StIdle;
                  end
               end else begin
                  r_baud_cnt <= r_baud_cnt + CW'(1);
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign tx      = r_tx;
   assign tx_busy = r_busy;
   assign tx_done = r_done;

endmodule

// File: tb/tb_watch_time_tx.sv
// Directed bench for watch_time_tx at BIT_CYC=100; expected bytes follow WATCH_TIME_TX_CRLF_EN.
module tb_watch_time_tx;

   localparam int unsigned CLK_FREQ = 100_000_000;
   localparam int unsigned BAUD     = 1_000_000;
   localparam int          B        = 100;
`ifdef WATCH_TIME_TX_CRLF_EN
   localparam int          NCHAR    = 13;
`else
   localparam int          NCHAR    = 11;
`endif
   localparam int          TOTAL    = NCHAR * 10 * B;

   logic       clk      = 1'b0;
   logic       rst      = 1'b0;
   logic       send_req = 1'b0;
   logic [4:0] hour     = '0;
   logic [5:0] min      = '0;
   logic [5:0] sec      = '0;
   logic [6:0] csec     = '0;
   logic       tx;
   logic       tx_busy;
   logic       tx_done;

   int n_chk  = 0;
   int n_pass = 0;

   logic [7:0] exp_b [13];
   logic [7:0] got_b [13];

   watch_time_tx #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD)
   ) u_dut (
      .clk      (clk),
      .rst      (rst),
      .send_req (send_req),
      .hour     (hour),
      .min      (min),
      .sec      (sec),
      .csec     (csec),
      .tx       (tx),
      .tx_busy  (tx_busy),
      .tx_done  (tx_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   task automatic set_exp(input logic [7:0] c0, c1, c3, c4, c6, c7, c9, c10);
      exp_b[0]  = c0;    exp_b[1]  = c1;    exp_b[2]  = 8'h3A;
      exp_b[3]  = c3;    exp_b[4]  = c4;    exp_b[5]  = 8'h3A;
      exp_b[6]  = c6;    exp_b[7]  = c7;    exp_b[8]  = 8'h2E;
      exp_b[9]  = c9;    exp_b[10] = c10;   exp_b[11] = 8'h0D;
      exp_b[12] = 8'h0A;
   endtask

   // k counts the negedge after request edge N+k; mid-bit samples at k%B == B/2.
   task automatic run_frame(input string name, input bit wait_edge, input int drop_k,
                            input int pulse_k);
      int busy_err = 0;
      int fram_err = 0;
      int done_cnt = 0;
      for (int c = 0; c < 13; c++) got_b[c] = '0;
      if (wait_edge) @(posedge clk);
      for (int k = 0; k <= TOTAL; k++) begin
         @(negedge clk);
         if (tx_done === 1'b1) done_cnt++;
         if (k < TOTAL) begin
            if (tx_busy !== 1'b1 || tx_done !== 1'b0) busy_err++;
         end else begin
            chk({name, " done_at_end"}, 32'(tx_done), 32'd1);
            chk({name, " busy_fall"}, 32'(tx_busy), 32'd0);
         end
         if (k == 0) chk({name, " start_edge"}, 32'(tx), 32'd0);
         if (k < TOTAL && (k % B) == B / 2) begin
            int bi = k / B;
            int c  = bi / 10;
            int j  = bi % 10;
            if (j == 0) begin
               if (tx !== 1'b0) fram_err++;
            end else if (j == 9) begin
               if (tx !== 1'b1) fram_err++;
            end else begin
               got_b[c] = {tx, got_b[c][7:1]};
            end
         end
         if (k == drop_k) send_req = 1'b0;
         if (k == pulse_k) begin
            send_req = 1'b1;
            hour     = 5'd23;
         end
         if (pulse_k >= 0 && k == pulse_k + 1) send_req = 1'b0;
      end
      for (int c = 0; c < NCHAR; c++)
         chk($sformatf("%s byte%0d", name, c), 32'(got_b[c]), 32'(exp_b[c]));
      chk({name, " busy_errs"}, busy_err, 0);
      chk({name, " framing_errs"}, fram_err, 0);
      chk({name, " done_pulses"}, done_cnt, 1);
   endtask

   task automatic check_idle(input string name, input int cycles);
      int err = 0;
      for (int k = 0; k < cycles; k++) begin
         @(negedge clk);
         if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) err++;
      end
      chk({name, " idle_errs"}, err, 0);
   endtask

   initial begin
      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst tx", 32'(tx), 32'd1);
      chk("rst busy", 32'(tx_busy), 32'd0);
      chk("rst done", 32'(tx_done), 32'd0);
      rst = 1'b1;
      check_idle("post_rst", 2000);

      // 12:34:56.78, single-clock request.
      hour = 5'd12; min = 6'd34; sec = 6'd56; csec = 7'd78;
      set_exp(8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38);
      send_req = 1'b1;
      run_frame("rpt1", 1'b1, 0, -1);
      check_idle("gap1", 50);

      // All zero; second request and hour change mid-frame must not matter.
      hour = '0; min = '0; sec = '0; csec = '0;
      set_exp(8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30);
      send_req = 1'b1;
      run_frame("zero", 1'b1, 0, 5 * B);
      check_idle("no_extra", 3 * B);

      // send_req held: second frame starts one clock after tx_done.
      hour = 5'd1; min = 6'd2; sec = 6'd3; csec = 7'd4;
      set_exp(8'h30, 8'h31, 8'h30, 8'h32, 8'h30, 8'h33, 8'h30, 8'h34);
      send_req = 1'b1;
      run_frame("held1", 1'b1, -1, -1);
      run_frame("held2", 1'b0, 0, -1);
      check_idle("gap2", 50);

      // Reset during char 4 aborts at once; no resume afterwards.
      hour = 5'd12; min = 6'd34; sec = 6'd56; csec = 7'd78;
      send_req = 1'b1;
      @(posedge clk);
      for (int k = 0; k <= 40 * B + 30; k++) begin
         @(negedge clk);
         if (k == 0) send_req = 1'b0;
      end
      chk("pre_abort busy", 32'(tx_busy), 32'd1);
      rst = 1'b0;
      #1;
      chk("abort tx", 32'(tx), 32'd1);
      chk("abort busy", 32'(tx_busy), 32'd0);
      chk("abort done", 32'(tx_done), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      check_idle("no_resume", 3 * B);

      // Out-of-range fields wrap: 31:59:63.127 -> "31:59:63.27".
      hour = 5'd31; min = 6'd59; sec = 6'd63; csec = 7'd127;
      set_exp(8'h33, 8'h31, 8'h35, 8'h39, 8'h36, 8'h33, 8'h32, 8'h37);
      send_req = 1'b1;
      run_frame("wrap", 1'b1, 0, -1);
      check_idle("end", 50);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
